// File: rtl/vc_writeback_buffer.sv
// Write-back buffer behind the victim cache: queues evicted 128-bit lines,
// drains them to physical memory one at a time and answers snoops from L2 misses.
module vc_writeback_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [ADDR_W-1:0] snoop_address,
  output logic              snoop_hit,
  output logic [DATA_W-1:0] snoop_data,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count, count_nxt;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              push, pop, alloc;
  logic              co_hit;
  logic [PTR_W-1:0]  co_idx;
  logic [PTR_W-1:0]  sidx;

  assign wb_ready = (count != CNT_FULL);
  assign empty    = (count == '0);
  assign push     = wb_valid && wb_ready;
  assign pop      = (state == WRITE) && pmem_resp;
  assign alloc    = push && !co_hit;

  // The head under an active write is frozen so the memory request stays stable.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_mem[i] == wb_address) &&
          !((PTR_W'(i) == head) && (state == WRITE))) begin
        co_hit = 1'b1;
        co_idx = PTR_W'(i);
      end
    end
  end

  // Walk from oldest to newest so the newest matching copy wins.
  always_comb begin
    snoop_hit  = 1'b0;
    snoop_data = '0;
    sidx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      sidx = head + PTR_W'(i);
      if (valid[sidx] && (addr_mem[sidx] == snoop_address)) begin
        snoop_hit  = 1'b1;
        snoop_data = data_mem[sidx];
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({alloc, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = WRITE;
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = {addr_mem[head], 4'b0000};
        pmem_wdata   = data_mem[head];
        if (pmem_resp) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_ONE;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_ONE;
      end
    end
  end

  // Line storage carries no reset; the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      if (co_hit) begin
        data_mem[co_idx] <= wb_data;
      end else begin
        addr_mem[tail] <= wb_address;
        data_mem[tail] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// Bench for vc_writeback_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the buffer.
module tb_vc_writeback_buffer;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wb_valid = 1'b0;
  logic [11:0]  wb_address = '0;
  logic [127:0] wb_data = '0;
  logic         wb_ready;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [11:0]  snoop_address = '0;
  logic         snoop_hit;
  logic [127:0] snoop_data;
  logic         empty;

  vc_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(128)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data), .wb_ready(wb_ready),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .snoop_address(snoop_address), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]  a;
    logic [127:0] d;
  } ent_t;

  ent_t q[$];          // buffered lines, oldest first
  bit   busy;          // a memory write is being presented
  bit   gap;           // the cycle right after a completed write
  ent_t drained[$];    // lines seen at the start of each memory write
  logic prev_write;
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit   push, pop, start;
    int   j;
    ent_t e;
    if (reset) begin
      q.delete();
      busy = 0;
      gap  = 0;
    end else begin
      push  = wb_valid && (q.size() != DEPTH);
      pop   = busy && pmem_resp;
      start = !busy && !gap && (q.size() != 0);
      if (push) begin
        j = -1;
        for (int k = 0; k < q.size(); k++)
          if (q[k].a == wb_address && !(k == 0 && busy)) j = k;
        if (j >= 0) begin
          e = q[j];
          e.d = wb_data;
          q[j] = e;
        end else begin
          e.a = wb_address;
          e.d = wb_data;
          q.push_back(e);
        end
      end
      if (pop) void'(q.pop_front());
      gap  = pop;
      busy = busy ? !pmem_resp : start;
    end
  endtask

  task automatic compare();
    logic         exp_hit;
    logic [127:0] exp_sd;
    ent_t         e;
    exp_hit = 1'b0;
    exp_sd  = '0;
    for (int k = 0; k < q.size(); k++)
      if (q[k].a == snoop_address) begin
        exp_hit = 1'b1;
        exp_sd  = q[k].d;
      end
    chk("pmem_write", pmem_write, busy);
    if (busy && q.size() != 0) begin
      chk("pmem_address", pmem_address, {q[0].a, 4'h0});
      chk("pmem_wdata", pmem_wdata, q[0].d);
    end
    chk("wb_ready", wb_ready, q.size() != DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("snoop_hit", snoop_hit, exp_hit);
    chk("snoop_data", snoop_data, exp_sd);
    if (pmem_write && !prev_write) begin
      e.a = pmem_address[15:4];
      e.d = pmem_wdata;
      drained.push_back(e);
    end
    prev_write = pmem_write;
  endtask

  // One clock: the edge consumes the previously applied inputs, then new ones are applied.
  task automatic step(input logic r, input logic v, input logic [11:0] a,
                      input logic [127:0] d, input logic resp, input logic [11:0] s);
    @(posedge clk);
    model_edge();
    #1;
    reset = r; wb_valid = v; wb_address = a; wb_data = d;
    pmem_resp = resp; snoop_address = s;
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input logic resp, input logic [11:0] s);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, '0, resp, s);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 12'h000, '0, 1'b0, 12'h000);
    idle(1, 1'b0, 12'h000);
    drained.delete();
  endtask

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D1  = {16{8'h11}};
  localparam logic [127:0] D2  = {16{8'h22}};
  localparam logic [127:0] D3  = {16{8'h33}};

  initial begin
    n_cmp = 0; n_fail = 0; busy = 0; gap = 0; prev_write = 1'b0;

    // Reset state
    do_reset();
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 16'h0000);
    chk("rst_pmem_wdata", pmem_wdata, 128'h0);
    chk("rst_wb_ready", wb_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_snoop_hit", snoop_hit, 1'b0);

    // Single line
    step(1'b0, 1'b1, 12'h123, DA5, 1'b0, 12'h123);
    chk("single_push_not_visible", snoop_hit, 1'b0);
    idle(1, 1'b0, 12'h123);
    chk("single_snoop_hit", snoop_hit, 1'b1);
    chk("single_idle_low", pmem_write, 1'b0);
    idle(1, 1'b0, 12'h123);
    chk("single_write", pmem_write, 1'b1);
    chk("single_addr", pmem_address, 16'h1230);
    chk("single_data", pmem_wdata, DA5);
    idle(2, 1'b0, 12'h000);
    idle(1, 1'b1, 12'h000);
    idle(1, 1'b0, 12'h000);
    chk("single_gap_low", pmem_write, 1'b0);
    chk("single_empty", empty, 1'b1);
    idle(1, 1'b0, 12'h000);
    chk("single_idle_after_gap", pmem_write, 1'b0);

    // Full / backpressure
    do_reset();
    step(1'b0, 1'b1, 12'h001, D1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 12'h002, D2, 1'b0, 12'h000);
    step(1'b0, 1'b1, 12'h003, D3, 1'b0, 12'h003);
    chk("full_ready_low", wb_ready, 1'b0);
    chk("full_writing", pmem_write, 1'b1);
    step(1'b0, 1'b1, 12'h003, D3, 1'b0, 12'h003);
    step(1'b0, 1'b1, 12'h003, D3, 1'b1, 12'h003);
    step(1'b0, 1'b1, 12'h003, D3, 1'b0, 12'h003);
    chk("full_no_bypass", snoop_hit, 1'b0);
    chk("full_ready_after_pop", wb_ready, 1'b1);
    idle(1, 1'b0, 12'h003);
    chk("full_third_accepted", snoop_hit, 1'b1);
    idle(14, 1'b1, 12'h000);
    chk("full_drain_count", drained.size(), 3);
    chk("full_drain0", {drained[0].a, 4'h0}, 16'h0010);
    chk("full_drain1", {drained[1].a, 4'h0}, 16'h0020);
    chk("full_drain2", {drained[2].a, 4'h0}, 16'h0030);

    // Coalesce
    do_reset();
    step(1'b0, 1'b1, 12'h040, DA5, 1'b0, 12'h000);
    idle(2, 1'b0, 12'h000);
    chk("co_writing", pmem_write, 1'b1);
    step(1'b0, 1'b1, 12'h050, D1, 1'b0, 12'h050);
    step(1'b0, 1'b1, 12'h050, D2, 1'b0, 12'h050);
    chk("co_first_data", snoop_data, D1);
    step(1'b0, 1'b1, 12'h050, D2, 1'b1, 12'h050);
    step(1'b0, 1'b1, 12'h050, D2, 1'b0, 12'h050);
    idle(1, 1'b0, 12'h050);
    chk("co_snoop_new", snoop_data, D2);
    chk("co_single_entry", wb_ready, 1'b1);
    idle(12, 1'b1, 12'h000);
    chk("co_drain_count", drained.size(), 2);
    chk("co_addr", {drained[1].a, 4'h0}, 16'h0500);
    chk("co_data", drained[1].d, D2);

    // Head hazard
    do_reset();
    step(1'b0, 1'b1, 12'h040, D1, 1'b0, 12'h000);
    idle(2, 1'b0, 12'h000);
    step(1'b0, 1'b1, 12'h040, D3, 1'b0, 12'h040);
    chk("hz_snoop_old", snoop_data, D1);
    idle(1, 1'b0, 12'h040);
    chk("hz_snoop_hit", snoop_hit, 1'b1);
    chk("hz_snoop_newest", snoop_data, D3);
    chk("hz_allocated", wb_ready, 1'b0);
    idle(12, 1'b1, 12'h000);
    chk("hz_drain_count", drained.size(), 2);
    chk("hz_first", drained[0].d, D1);
    chk("hz_second_addr", {drained[1].a, 4'h0}, 16'h0400);
    chk("hz_second_data", drained[1].d, D3);

    // Snoop hit/miss
    do_reset();
    step(1'b0, 1'b1, 12'h010, D1, 1'b0, 12'h011);
    step(1'b0, 1'b1, 12'h011, D2, 1'b0, 12'h011);
    idle(1, 1'b0, 12'h011);
    chk("snp_hit", snoop_hit, 1'b1);
    chk("snp_data", snoop_data, D2);
    idle(1, 1'b0, 12'h099);
    chk("snp_miss", snoop_hit, 1'b0);
    chk("snp_miss_data", snoop_data, 128'h0);

    // Reset while a write is outstanding
    chk("rw_writing", pmem_write, 1'b1);
    step(1'b1, 1'b0, 12'h000, '0, 1'b0, 12'h010);
    idle(1, 1'b0, 12'h010);
    chk("rw_write_low", pmem_write, 1'b0);
    chk("rw_empty", empty, 1'b1);
    chk("rw_ready", wb_ready, 1'b1);
    chk("rw_snoop", snoop_hit, 1'b0);
    idle(1, 1'b1, 12'h000);
    idle(3, 1'b0, 12'h000);
    chk("rw_stray_resp", pmem_write, 1'b0);
    chk("rw_still_empty", empty, 1'b1);

    // Random traffic over a small address pool to exercise coalescing and hazards
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) != 0,
           12'($urandom_range(0, 5)),
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) == 0,
           12'($urandom_range(0, 6)));
    end
    idle(2, 1'b0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_writeback_buffer.md
Name: vc_writeback_buffer

Overview:
- Consumer side of the victim-cache eviction path. Accepts 128-bit lines leaving the victim cache on the wb_* interface and queues them in a small FIFO.
- Drains queued lines to physical memory with the pmem_write/pmem_resp handshake.
- Provides a combinational snoop port so an L2 miss can be served from a line still waiting in the buffer, which keeps memory coherent.

Parameters:
DEPTH, 2, number of buffered lines; must be a power of 2 and at least 2.
ADDR_W, 12, line-address width (16-bit byte address minus 4 offset bits).
DATA_W, 128, line width in bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
wb_valid  in  1  victim cache presents a line.
wb_address  in  ADDR_W  line address of the presented line.
wb_data  in  DATA_W  line data.
wb_ready  out  1  buffer can accept; a transfer occurs when wb_valid and wb_ready are both high at a clock edge.
pmem_write  out  1  write request to physical memory.
pmem_address  out  16  equals {head line address, 4'b0000}.
pmem_wdata  out  DATA_W  data of the head line.
pmem_resp  in  1  memory has completed the write.
snoop_address  in  ADDR_W  L2 miss line address to check.
snoop_hit  out  1  a valid entry matches snoop_address (combinational).
snoop_data  out  DATA_W  data of the matching entry; 0 when snoop_hit is 0.
empty  out  1  no valid entries.

Behaviour:
- Reset, synchronous with priority over everything else:
  - count=0, head/tail pointers=0, all valid bits 0, state=IDLE.
  - Outputs: pmem_write=0, pmem_address=0, pmem_wdata=0, wb_ready=1, empty=1, snoop_hit=0.
  - Reset during WRITE abandons the pending entry; pmem_write is 0 in the cycle after reset.
- wb_ready = (count != DEPTH). It uses the registered count, so there is no same-cycle bypass: when full, a pop does not allow a push in that same cycle.
- Push (wb_valid & wb_ready):
  - Coalesce: if wb_address matches a valid entry that is not the head in state WRITE, overwrite that entry's data in place. count is unchanged.
  - Otherwise write the entry at tail, set it valid, tail+1 modulo DEPTH, count+1.
  - A line matching the head while the head is in WRITE always allocates a new entry.
- FSM states: IDLE, WRITE, GAP.
  - IDLE: if count!=0, go to WRITE the next cycle. pmem_write=0.
  - WRITE: pmem_write=1. pmem_address/pmem_wdata are driven from the head entry and stay stable, because the head is neither coalesced nor moved while in WRITE.
  - WRITE, pmem_resp=1: pop the head (clear its valid bit, head+1 modulo DEPTH, count-1) and go to GAP.
  - WRITE, pmem_resp=0: hold in WRITE.
  - GAP: pmem_write=0 for exactly one cycle, then go to IDLE. Back-to-back writes are therefore separated by at least 2 low cycles (GAP, IDLE).
- Simultaneous push and pop when not full: count is unchanged, and both pointers advance.
- pmem_resp outside WRITE is ignored.
- Snoop:
  - Compare snoop_address against every valid entry. With multiple matches (possible only when the head is in WRITE and a newer copy exists), the newest entry wins.
  - The entry being popped this cycle still counts as a hit in that cycle.
  - A line pushed this cycle is not visible until the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Latency: from a push into an empty buffer to pmem_write=1 is 2 cycles (count updates, IDLE to WRITE, then WRITE is registered).

Test Plan:
- Single line: after reset, push addr 0x123, data 0xA5..A5; pmem_resp arrives 3 cycles after pmem_write rises -> pmem_write=1 with pmem_address=0x1230 and pmem_wdata=0xA5..A5; one GAP cycle follows; empty=1 afterwards.
- Full/backpressure: push 0x001 and 0x002 with pmem_resp held 0 -> wb_ready=0. A third push (0x003) is not accepted until the cycle after pmem_resp pops 0x001. Drain order is 0x0010, 0x0020, 0x0030.
- Coalesce: push 0x050 (data D1) while a pmem write to 0x040 is outstanding, then push 0x050 (data D2) -> count stays 2; the later write shows pmem_address=0x0500, pmem_wdata=D2.
- Head hazard: while the write of 0x040 (data D1) is outstanding, push 0x040 with data D3 -> a new entry is allocated; snoop 0x040 returns D3; the next pmem write is 0x0400 with D3.
- Snoop miss/hit: with entries 0x010/0x011 buffered, snoop 0x011 -> snoop_hit=1 with the correct data; snoop 0x099 -> snoop_hit=0, snoop_data=0.
- Reset mid-WRITE: assert reset while pmem_write=1 -> the next cycle shows pmem_write=0, empty=1, wb_ready=1; a later stray pmem_resp has no effect.
